// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the big-endian data-memory responder.
// Holds the FSM state encoding, access-size codes, counter width and the
// lane helpers that map a byte offset onto the big-endian word layout.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;

  localparam int CNT_W = 16;

  // Lane i of a word holds the byte at offset i, so a byte access enables a
  // single lane and a word access enables all four.
  function automatic logic [3:0] lane_mask(input logic is_byte, input logic [1:0] offset);
    logic [3:0] mask;
    if (is_byte == SZ_BYTE) begin
      mask = 4'b0001 << offset;
    end else begin
      mask = 4'b1111;
    end
    return mask;
  endfunction

  // The lowest-addressed byte sits in bits 31:24 of the assembled word.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] offset);
    logic [7:0] sel;
    case (offset)
      2'd0:    sel = word[31:24];
      2'd1:    sel = word[23:16];
      2'd2:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH_BYTES x 8 storage organised as words of four byte
// lanes. Writes are per-lane and synchronous; the word containing the
// addressed byte is assembled combinationally in big-endian order so the
// responder can register it on the commit edge. Contents are never cleared.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 32,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic [3:0]        lane_we,
  input  logic [ADDR_W-3:0] word_idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // Lane i takes its byte from the big-endian slot (3-i) of the write word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[{word_idx, 2'(i)}] <= wdata[(3-i)*8 +: 8];
      end
    end
  end

  assign rdata = {mem[{word_idx, 2'd0}],
                  mem[{word_idx, 2'd1}],
                  mem[{word_idx, 2'd2}],
                  mem[{word_idx, 2'd3}]};

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle, byte-addressed, big-endian data-memory slave
// with a valid/ready request and response handshake. A request is accepted
// in IDLE, waits WAIT_CYCLES cycles, commits on the edge entering RESP and
// holds its response until resp_ready. Misaligned word accesses report
// resp_err without touching memory.
// Optional build macro DMEM_ACCESS_COUNT_EN adds saturating rd_count and
// wr_count outputs that count committed, non-error loads and stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`endif
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_nxt;
  logic              commit;

  logic              lat_write;
  logic              lat_byte;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              acc_write;
  logic              acc_byte;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;

  logic              misaligned;
  logic [3:0]        lane_we;
  logic [31:0]       arr_wdata;
  logic [31:0]       arr_rdata;
  logic [31:0]       load_data;

  logic [31:0]       rdata_q;
  logic              err_q;

  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  // Next-state logic; commit marks the edge that moves the FSM into RESP.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // With no wait states the commit happens on the accepting edge itself, so
  // the live request fields are used in IDLE and the latched copy otherwise.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_byte  = req_byte;
      acc_addr  = req_addr[ADDR_W-1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_write = lat_write;
      acc_byte  = lat_byte;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  // Decode the access: error check, lane enables and write/read data steering.
  // Reset gates the enables so an abandoned store can never land.
  always_comb begin
    misaligned = (acc_byte == SZ_WORD) && (acc_addr[1:0] != 2'd0);
    lane_we    = 4'b0000;
    if (commit && acc_write && !misaligned && !reset) begin
      lane_we = lane_mask(acc_byte, acc_addr[1:0]);
    end
    if (acc_byte == SZ_BYTE) begin
      arr_wdata = {4{acc_wdata[7:0]}};
      load_data = {24'b0, pick_byte(arr_rdata, acc_addr[1:0])};
    end else begin
      arr_wdata = acc_wdata;
      load_data = arr_rdata;
    end
  end

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk     (clk),
    .lane_we (lane_we),
    .word_idx(acc_addr[ADDR_W-1:2]),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  // State, wait counter and response registers; response captured at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (commit) begin
        err_q   <= misaligned;
        rdata_q <= (acc_write || misaligned) ? 32'd0 : load_data;
      end
    end
  end

  // Request fields are captured on acceptance and only read after IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      lat_write <= req_write;
      lat_byte  <= req_byte;
      lat_addr  <= req_addr[ADDR_W-1:0];
      lat_wdata <= req_wdata;
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  // Saturating counters of committed, non-error loads and stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit && !misaligned) begin
      if (acc_write) begin
        if (wr_count != {CNT_W{1'b1}}) wr_count <= wr_count + 1'b1;
      end else begin
        if (rd_count != {CNT_W{1'b1}}) rd_count <= rd_count + 1'b1;
      end
    end
  end
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Instance u_dut0 uses WAIT_CYCLES=1, u_dut1 uses WAIT_CYCLES=0; both share
// the request bus and sel steers req_valid and the observed outputs.
// Build with DMEM_ACCESS_COUNT_EN defined to also check rd_count/wr_count.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic        resp_valid0, resp_valid1;
  logic [31:0] resp_rdata0, resp_rdata1;
  logic        resp_err0, resp_err1;

  logic        obs_req_ready;
  logic        obs_resp_valid;
  logic [31:0] obs_resp_rdata;
  logic        obs_resp_err;

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rd_count0, rd_count1, wr_count0, wr_count1;
  logic [15:0] obs_rd_count, obs_wr_count;
  assign obs_rd_count = sel ? rd_count1 : rd_count0;
  assign obs_wr_count = sel ? wr_count1 : wr_count0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;
  logic last_wr;
  logic last_misal;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  assign req_valid0     = req_valid & ~sel;
  assign req_valid1     = req_valid & sel;
  assign obs_req_ready  = sel ? req_ready1  : req_ready0;
  assign obs_resp_valid = sel ? resp_valid1 : resp_valid0;
  assign obs_resp_rdata = sel ? resp_rdata1 : resp_rdata0;
  assign obs_resp_err   = sel ? resp_err1   : resp_err0;

  dmem_responder #(.DEPTH_BYTES(32), .ADDR_W(5), .WAIT_CYCLES(1)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid0),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata0),
    .resp_err  (resp_err0)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count  (rd_count0),
    .wr_count  (wr_count0)
`endif
  );

  dmem_responder #(.DEPTH_BYTES(32), .ADDR_W(5), .WAIT_CYCLES(0)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid1),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1),
    .resp_err  (resp_err1)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count  (rd_count1),
    .wr_count  (wr_count1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkCounts(input string tag);
`ifdef DMEM_ACCESS_COUNT_EN
    checkOutput({tag, "_rd_count"}, {16'd0, obs_rd_count}, 32'(exp_rd));
    checkOutput({tag, "_wr_count"}, {16'd0, obs_wr_count}, 32'(exp_wr));
`else
    $display("[TB] %s counters not built", tag);
`endif
  endtask

  // Present one request for exactly one accepting edge, then drop it.
  task automatic applyStimulus(input logic wr, input logic by, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_byte   = by;
    req_addr   = addr;
    req_wdata  = wdata;
    last_wr    = wr;
    last_misal = !by && (addr[1:0] != 2'd0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_wdata  = $urandom;
  endtask

  // Count edges from acceptance until resp_valid, bounded.
  task automatic waitResp(output int edges);
    edges = 1;
    while (!obs_resp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("resp_arrives", {31'd0, obs_resp_valid}, 32'd1);
    if (obs_resp_valid && !last_misal) begin
      if (last_wr) exp_wr++;
      else exp_rd++;
    end
  endtask

  task automatic doAccess(input logic wr, input logic by, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int edges);
    applyStimulus(wr, by, addr, wdata);
    waitResp(edges);
    rdata = obs_resp_rdata;
    err   = obs_resp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hAD; exp_bytes[2] = 8'hBE; exp_bytes[3] = 8'hEF;

    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, obs_req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, obs_resp_valid}, 32'd0);
    checkOutput("rst_rdata", obs_resp_rdata, 32'd0);
    checkOutput("rst_err", {31'd0, obs_resp_err}, 32'd0);
    checkCounts("rst");
    reset = 1'b0;

    $display("[TB] word store/load and byte loads, WAIT_CYCLES=1");
    doAccess(1'b1, 1'b0, 32'h08, 32'hDEADBEEF, rd, er, lat);
    checkOutput("st08_lat", 32'(lat), 32'd2);
    checkOutput("st08_rdata", rd, 32'd0);
    checkOutput("st08_err", {31'd0, er}, 32'd0);
    doAccess(1'b0, 1'b0, 32'h08, 32'h0, rd, er, lat);
    checkOutput("ld08_lat", 32'(lat), 32'd2);
    checkOutput("ld08_rdata", rd, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      doAccess(1'b0, 1'b1, 32'h08 + 32'(i), 32'h0, rd, er, lat);
      checkOutput("ldb_rdata", rd, {24'd0, exp_bytes[i]});
    end
    checkCounts("after_loads");

    $display("[TB] byte store into a word");
    doAccess(1'b1, 1'b0, 32'h08, 32'h11223344, rd, er, lat);
    doAccess(1'b1, 1'b1, 32'h0A, 32'hFFFFFF5A, rd, er, lat);
    checkOutput("stb0a_err", {31'd0, er}, 32'd0);
    doAccess(1'b0, 1'b0, 32'h08, 32'h0, rd, er, lat);
    checkOutput("ld08_merge", rd, 32'h11225A44);

    $display("[TB] misaligned word accesses");
    doAccess(1'b1, 1'b0, 32'h04, 32'h01020304, rd, er, lat);
    doAccess(1'b1, 1'b0, 32'h06, 32'h99999999, rd, er, lat);
    checkOutput("st06_err", {31'd0, er}, 32'd1);
    checkOutput("st06_rdata", rd, 32'd0);
    checkOutput("st06_lat", 32'(lat), 32'd2);
    doAccess(1'b0, 1'b0, 32'h05, 32'h0, rd, er, lat);
    checkOutput("ld05_err", {31'd0, er}, 32'd1);
    checkOutput("ld05_rdata", rd, 32'd0);
    doAccess(1'b0, 1'b0, 32'h04, 32'h0, rd, er, lat);
    checkOutput("ld04_intact", rd, 32'h01020304);
    checkOutput("ld04_err", {31'd0, er}, 32'd0);
    checkCounts("after_misaligned");

    $display("[TB] address wrap");
    doAccess(1'b1, 1'b0, 32'h24, 32'hCAFEF00D, rd, er, lat);
    doAccess(1'b0, 1'b0, 32'h04, 32'h0, rd, er, lat);
    checkOutput("ld04_wrap", rd, 32'hCAFEF00D);

    $display("[TB] response back-pressure");
    resp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h04, 32'h0);
    waitResp(lat);
    checkOutput("hold_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 32'h04; req_wdata = 32'hBAD0BAD0;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("hold_valid", {31'd0, obs_resp_valid}, 32'd1);
      checkOutput("hold_rdata", obs_resp_rdata, 32'hCAFEF00D);
      checkOutput("hold_req_ready", {31'd0, obs_req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_valid", {31'd0, obs_resp_valid}, 32'd0);
    checkOutput("release_req_ready", {31'd0, obs_req_ready}, 32'd1);
    doAccess(1'b0, 1'b0, 32'h04, 32'h0, rd, er, lat);
    checkOutput("ld04_no_ghost", rd, 32'hCAFEF00D);
    checkCounts("after_hold");

    $display("[TB] reset during WAIT abandons store");
    doAccess(1'b1, 1'b0, 32'h10, 32'h00000000, rd, er, lat);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h12345678);
    checkOutput("inwait_valid", {31'd0, obs_resp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    checkOutput("rstwait_valid", {31'd0, obs_resp_valid}, 32'd0);
    checkOutput("rstwait_req_ready", {31'd0, obs_req_ready}, 32'd1);
    doAccess(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("ld10_abandoned", rd, 32'h00000000);
    checkCounts("after_rstwait");

    $display("[TB] WAIT_CYCLES=0 instance");
    sel = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    doAccess(1'b1, 1'b0, 32'h10, 32'h00000000, rd, er, lat);
    checkOutput("w0_st_lat", 32'(lat), 32'd1);
    resp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h12345678);
    waitResp(lat);
    checkOutput("w0_st2_lat", 32'(lat), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_ready = 1'b1;
    exp_rd = 0; exp_wr = 0;
    checkOutput("w0_rst_valid", {31'd0, obs_resp_valid}, 32'd0);
    checkOutput("w0_rst_req_ready", {31'd0, obs_req_ready}, 32'd1);
    doAccess(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("w0_ld_lat", 32'(lat), 32'd1);
    checkOutput("w0_ld10", rd, 32'h12345678);
    doAccess(1'b0, 1'b1, 32'h13, 32'h0, rd, er, lat);
    checkOutput("w0_ldb13", rd, 32'h00000078);
    doAccess(1'b0, 1'b0, 32'h12, 32'h0, rd, er, lat);
    checkOutput("w0_ld12_err", {31'd0, er}, 32'd1);
    checkCounts("w0_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
